// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit.
//   MODE_ADD / MODE_SUB : encodings of the in_sub mode input
//   slice_width()       : per-stage slice width, WIDTH/STAGES, or 0 when the
//                         combination is illegal (STAGES of 0, larger than WIDTH,
//                         or not dividing WIDTH)
package adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // A zero result makes every [C-1:0] slice declaration degenerate, so an
  // illegal WIDTH/STAGES pair cannot elaborate into a silently wrong adder.
  function automatic int unsigned slice_width(input int unsigned width,
                                              input int unsigned stages);
    if (stages == 0 || stages > width || (width % stages) != 0) begin
      return 0;
    end
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational C-bit adder slice.
//   a, b       : slice operands (b already inverted for subtraction)
//   carry_in   : carry into bit 0 of the slice
//   sum        : C-bit slice sum
//   carry_out  : carry out of the slice MSB
//   msb_carry  : carry into the slice MSB, used for signed overflow
module adder_slice #(
  parameter int unsigned C = 8
) (
  input  logic [C-1:0] a,
  input  logic [C-1:0] b,
  input  logic         carry_in,
  output logic [C-1:0] sum,
  output logic         carry_out,
  output logic         msb_carry
);

  logic [C:0] total;

  assign total     = {1'b0, a} + {1'b0, b} + {{C{1'b0}}, carry_in};
  assign sum       = total[C-1:0];
  assign carry_out = total[C];
  // The MSB sum bit is a ^ b ^ carry-in at that position, so the carry in
  // can be recovered without a second adder.
  assign msb_carry = a[C-1] ^ b[C-1] ^ total[C-1];

endmodule

// File: rtl/pipelined_adder_n.sv
// Fully pipelined WIDTH-bit add/subtract unit with valid/ready handshake.
// The operation is split into STAGES carry-chained slices; stage k adds slice k
// and registers the result together with the operands still to be consumed.
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   : input handshake (in_ready = !out_valid || out_ready)
//   in_a, in_b          : operands
//   in_carry            : carry-in (add) / borrow-in (sub)
//   in_sub              : 0 = add, 1 = subtract
//   out_valid/out_ready : output handshake
//   out_sum             : result
//   out_carry           : final carry-out (sub: 1 = no borrow)
//   out_overflow        : signed two's-complement overflow
module pipelined_adder_n
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_carry,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_overflow
);

  localparam int unsigned C = slice_width(WIDTH, STAGES);

  logic              advance;
  logic [WIDTH-1:0]  b_eff;
  logic              carry0;

  // Register index k holds the outputs of stage k; index STAGES-1 is the
  // output register.
  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] carry_q, carry_d;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic              msb_carry [STAGES];
  logic              overflow_q, overflow_d;

  // Whole-pipeline stall: nothing moves unless the output slot can drain.
  assign advance  = !valid_q[STAGES-1] || out_ready;
  assign in_ready = advance;

  assign b_eff  = (in_sub == MODE_ADD) ? in_b : ~in_b;
  assign carry0 = in_carry ^ (in_sub == MODE_SUB);

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_cur;
    logic [WIDTH-1:0] b_cur;
    logic [WIDTH-1:0] sum_prev;
    logic             c_cur;
    logic             v_cur;
    logic [C-1:0]     s;
    logic             c_out;

    if (k == 0) begin : g_first
      assign a_cur    = in_a;
      assign b_cur    = b_eff;
      assign c_cur    = carry0;
      assign v_cur    = in_valid;
      assign sum_prev = '0;
    end else begin : g_next
      assign a_cur    = a_q[k-1];
      assign b_cur    = b_q[k-1];
      assign c_cur    = carry_q[k-1];
      assign v_cur    = valid_q[k-1];
      assign sum_prev = sum_q[k-1];
    end

    adder_slice #(
      .C(C)
    ) u_slice (
      .a        (a_cur[k*C +: C]),
      .b        (b_cur[k*C +: C]),
      .carry_in (c_cur),
      .sum      (s),
      .carry_out(c_out),
      .msb_carry(msb_carry[k])
    );

    assign valid_d[k] = v_cur;
    assign carry_d[k] = c_out;
    assign a_d[k]     = a_cur;
    assign b_d[k]     = b_cur;
    // Completed slices accumulate in place; bits above slice k stay zero.
    assign sum_d[k]   = sum_prev | (WIDTH'(s) << (k * C));
  end

  assign overflow_d = msb_carry[STAGES-1] ^ carry_d[STAGES-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q    <= '0;
      carry_q    <= '0;
      overflow_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else if (advance) begin
      valid_q    <= valid_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        sum_q[k] <= sum_d[k];
      end
    end
  end

  assign out_valid    = valid_q[STAGES-1];
  assign out_sum      = sum_q[STAGES-1];
  assign out_carry    = carry_q[STAGES-1];
  assign out_overflow = overflow_q;

endmodule

// File: tb/tb_pipelined_adder_n.sv
// Self-checking bench for pipelined_adder_n: three instances
// (32/2, 32/4, 64/8) exercised by directed scenarios plus a random stream.
module tb_pipelined_adder_n;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // WIDTH=32, STAGES=2
  logic        s2_in_valid, s2_in_ready, s2_in_carry, s2_in_sub;
  logic        s2_out_valid, s2_out_ready, s2_out_carry, s2_out_overflow;
  logic [31:0] s2_in_a, s2_in_b, s2_out_sum;
  // WIDTH=32, STAGES=4
  logic        s4_in_valid, s4_in_ready, s4_in_carry, s4_in_sub;
  logic        s4_out_valid, s4_out_ready, s4_out_carry, s4_out_overflow;
  logic [31:0] s4_in_a, s4_in_b, s4_out_sum;
  // WIDTH=64, STAGES=8
  logic        s8_in_valid, s8_in_ready, s8_in_carry, s8_in_sub;
  logic        s8_out_valid, s8_out_ready, s8_out_carry, s8_out_overflow;
  logic [63:0] s8_in_a, s8_in_b, s8_out_sum;

  pipelined_adder_n #(.WIDTH(32), .STAGES(2)) u_s2 (
    .clock(clock), .reset(reset),
    .in_valid(s2_in_valid), .in_ready(s2_in_ready), .in_a(s2_in_a), .in_b(s2_in_b),
    .in_carry(s2_in_carry), .in_sub(s2_in_sub),
    .out_valid(s2_out_valid), .out_ready(s2_out_ready), .out_sum(s2_out_sum),
    .out_carry(s2_out_carry), .out_overflow(s2_out_overflow)
  );

  pipelined_adder_n #(.WIDTH(32), .STAGES(4)) u_s4 (
    .clock(clock), .reset(reset),
    .in_valid(s4_in_valid), .in_ready(s4_in_ready), .in_a(s4_in_a), .in_b(s4_in_b),
    .in_carry(s4_in_carry), .in_sub(s4_in_sub),
    .out_valid(s4_out_valid), .out_ready(s4_out_ready), .out_sum(s4_out_sum),
    .out_carry(s4_out_carry), .out_overflow(s4_out_overflow)
  );

  pipelined_adder_n #(.WIDTH(64), .STAGES(8)) u_s8 (
    .clock(clock), .reset(reset),
    .in_valid(s8_in_valid), .in_ready(s8_in_ready), .in_a(s8_in_a), .in_b(s8_in_b),
    .in_carry(s8_in_carry), .in_sub(s8_in_sub),
    .out_valid(s8_out_valid), .out_ready(s8_out_ready), .out_sum(s8_out_sum),
    .out_carry(s8_out_carry), .out_overflow(s8_out_overflow)
  );

  task automatic test_reset();
    reset = 1'b0;
    #1;
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (s2_out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_s2_out_valid got %b want 0", s2_out_valid);
    end
    checks++;
    if (s2_out_sum !== 32'h0) begin
      errors++; $display("FAIL reset_s2_out_sum got %h want 0", s2_out_sum);
    end
    checks++;
    if ({s4_out_valid, s4_out_carry, s4_out_overflow} !== 3'b000) begin
      errors++;
      $display("FAIL reset_s4_flags got %b want 000", {s4_out_valid, s4_out_carry, s4_out_overflow});
    end
    checks++;
    if (s4_in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_s4_in_ready got %b want 1", s4_in_ready);
    end
    checks++;
    if (s8_out_sum !== 64'h0 || s8_out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_s8 got v=%b sum=%h want v=0 sum=0", s8_out_valid, s8_out_sum);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_add_wrap();
    @(negedge clock);
    s2_out_ready = 1'b1;
    s2_in_valid  = 1'b1;
    s2_in_a      = 32'hFFFF_FFFF;
    s2_in_b      = 32'h0000_0001;
    s2_in_carry  = 1'b0;
    s2_in_sub    = 1'b0;
    @(negedge clock);
    s2_in_valid = 1'b0;
    checks++;
    if (s2_out_valid !== 1'b0) begin
      errors++; $display("FAIL wrap_early_valid got %b want 0", s2_out_valid);
    end
    @(negedge clock);
    checks++;
    if (s2_out_valid !== 1'b1) begin
      errors++; $display("FAIL wrap_valid got %b want 1", s2_out_valid);
    end
    checks++;
    if ({s2_out_carry, s2_out_overflow, s2_out_sum} !== {1'b1, 1'b0, 32'h0000_0000}) begin
      errors++;
      $display("FAIL wrap_result got c=%b v=%b sum=%h want c=1 v=0 sum=00000000",
               s2_out_carry, s2_out_overflow, s2_out_sum);
    end
    @(negedge clock);
    checks++;
    if (s2_out_valid !== 1'b0) begin
      errors++; $display("FAIL wrap_drained got %b want 0", s2_out_valid);
    end
  endtask

  task automatic test_vectors();
    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic        vc [6];
    logic        vs [6];
    logic [31:0] es [6];
    logic        ec [6];
    logic        eo [6];
    int          w;
    va = '{32'h0000_0005, 32'h7FFF_FFFF, 32'h0000_000A, 32'h0000_FFFF, 32'h8000_0000, 32'h0};
    vb = '{32'h0000_0007, 32'h0000_0001, 32'h0000_0003, 32'h0000_FFFF, 32'h0000_0001, 32'h0};
    vc = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vs = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    es = '{32'hFFFF_FFFE, 32'h8000_0000, 32'h0000_0006, 32'h0001_FFFF, 32'h7FFF_FFFF,
           32'hFFFF_FFFF};
    ec = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    eo = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    s4_out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      s4_in_valid = 1'b1;
      s4_in_a     = va[i];
      s4_in_b     = vb[i];
      s4_in_carry = vc[i];
      s4_in_sub   = vs[i];
      @(negedge clock);
      s4_in_valid = 1'b0;
      w = 0;
      while (s4_out_valid !== 1'b1 && w < 10) begin
        @(negedge clock);
        w++;
      end
      checks++;
      if (w >= 10) begin
        errors++; $display("FAIL vec%0d_timeout got no out_valid want out_valid", i);
      end else if (s4_out_sum !== es[i]) begin
        errors++; $display("FAIL vec%0d_sum got %h want %h", i, s4_out_sum, es[i]);
      end
      checks++;
      if (s4_out_carry !== ec[i]) begin
        errors++; $display("FAIL vec%0d_carry got %b want %b", i, s4_out_carry, ec[i]);
      end
      checks++;
      if (s4_out_overflow !== eo[i]) begin
        errors++; $display("FAIL vec%0d_ovf got %b want %b", i, s4_out_overflow, eo[i]);
      end
    end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    logic [31:0] ta [8];
    logic [31:0] te [8];
    int          got = 0;
    ta = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444,
           32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 32'h8888_8888};
    te = '{32'h1111_1112, 32'h2222_2223, 32'h3333_3334, 32'h4444_4445,
           32'h5555_5556, 32'h6666_6667, 32'h7777_7778, 32'h8888_8889};
    s4_out_ready = 1'b1;
    s4_in_sub    = 1'b0;
    s4_in_carry  = 1'b0;
    s4_in_b      = 32'h0000_0001;
    for (int t = 0; t < 16; t++) begin
      @(negedge clock);
      if (s4_out_valid === 1'b1) begin
        checks++;
        if (got >= 8) begin
          errors++; $display("FAIL b2b_extra got beat %0d want 8 beats", got);
        end else begin
          if (t != got + 4) begin
            errors++; $display("FAIL b2b_timing got slot %0d want %0d", t, got + 4);
          end
          checks++;
          if (s4_out_sum !== te[got]) begin
            errors++; $display("FAIL b2b_sum%0d got %h want %h", got, s4_out_sum, te[got]);
          end
        end
        got++;
      end
      s4_in_valid = (t < 8);
      if (t < 8) s4_in_a = ta[t];
    end
    checks++;
    if (got != 8) begin
      errors++; $display("FAIL b2b_count got %0d want 8", got);
    end
  endtask

  task automatic test_stall();
    logic [31:0] te [6];
    int          pushed = 0;
    int          got = 0;
    logic        push, pop;
    te = '{32'h0000_0100, 32'h0000_0110, 32'h0000_0120, 32'h0000_0130, 32'h0000_0140,
           32'h0000_0150};
    s4_in_sub   = 1'b0;
    s4_in_carry = 1'b0;
    s4_in_b     = 32'h0000_00F0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clock);
      s4_out_ready = (t >= 7);
      s4_in_valid  = (pushed < 6);
      s4_in_a      = 32'(16 * (pushed + 1));
      #1;
      if (t >= 4 && t <= 6) begin
        checks++;
        if (s4_in_ready !== 1'b0) begin
          errors++; $display("FAIL stall_in_ready%0d got %b want 0", t, s4_in_ready);
        end
        checks++;
        if (s4_out_valid !== 1'b1 || s4_out_sum !== te[0]) begin
          errors++;
          $display("FAIL stall_hold%0d got v=%b sum=%h want v=1 sum=%h",
                   t, s4_out_valid, s4_out_sum, te[0]);
        end
      end
      pop  = s4_out_valid && s4_out_ready;
      push = s4_in_valid && s4_in_ready;
      if (pop) begin
        checks++;
        if (got >= 6) begin
          errors++; $display("FAIL stall_dup got beat %0d want 6 beats", got);
        end else if (s4_out_sum !== te[got]) begin
          errors++; $display("FAIL stall_sum%0d got %h want %h", got, s4_out_sum, te[got]);
        end
        got++;
      end
      if (push) pushed++;
    end
    checks++;
    if (got != 6 || pushed != 6) begin
      errors++; $display("FAIL stall_count got out=%0d in=%0d want 6/6", got, pushed);
    end
    s4_in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int got = 0;
    @(negedge clock);
    s4_out_ready = 1'b1;
    s4_in_sub    = 1'b0;
    s4_in_carry  = 1'b0;
    for (int t = 0; t < 3; t++) begin
      s4_in_valid = 1'b1;
      s4_in_a     = 32'(t + 1);
      s4_in_b     = 32'h0000_0100;
      @(negedge clock);
    end
    s4_in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (s4_out_valid !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre_valid got %b want 1", s4_out_valid);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({s4_out_valid, s4_out_carry, s4_out_overflow, s4_out_sum} !== 35'h0) begin
      errors++;
      $display("FAIL rstmid_clear got v=%b c=%b o=%b sum=%h want all 0",
               s4_out_valid, s4_out_carry, s4_out_overflow, s4_out_sum);
    end
    checks++;
    if (s4_in_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_in_ready got %b want 1", s4_in_ready);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    s4_in_valid = 1'b1;
    s4_in_a     = 32'h0000_000A;
    s4_in_b     = 32'h0000_0003;
    s4_in_carry = 1'b1;
    s4_in_sub   = 1'b1;
    @(negedge clock);
    s4_in_valid = 1'b0;
    for (int t = 0; t < 10; t++) begin
      if (s4_out_valid === 1'b1) begin
        checks++;
        if (got > 0) begin
          errors++; $display("FAIL rstmid_stale got extra beat sum=%h want none", s4_out_sum);
        end else if ({s4_out_carry, s4_out_sum} !== {1'b1, 32'h0000_0006}) begin
          errors++;
          $display("FAIL rstmid_result got c=%b sum=%h want c=1 sum=00000006",
                   s4_out_carry, s4_out_sum);
        end
        got++;
      end
      @(negedge clock);
    end
    checks++;
    if (got != 1) begin
      errors++; $display("FAIL rstmid_count got %0d want 1", got);
    end
  endtask

  task automatic test_random();
    logic [63:0] qs [$];
    logic        qc [$];
    logic        qo [$];
    logic [63:0] eb, es;
    logic [64:0] r;
    logic        ecarry, eovf;
    logic        push, pop;
    int          accepted = 0;
    int          popped = 0;
    for (int cyc = 0; cyc < 20000 && popped < 1000; cyc++) begin
      @(negedge clock);
      s8_in_valid  = (accepted < 1000) && ($urandom_range(0, 3) != 0);
      s8_in_a      = {$urandom, $urandom};
      s8_in_b      = {$urandom, $urandom};
      s8_in_carry  = ($urandom_range(0, 1) != 0);
      s8_in_sub    = ($urandom_range(0, 1) != 0);
      s8_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      pop  = s8_out_valid && s8_out_ready;
      push = s8_in_valid && s8_in_ready;
      if (pop) begin
        checks++;
        if (qs.size() == 0) begin
          errors++; $display("FAIL rand_spurious got sum=%h want no beat", s8_out_sum);
        end else begin
          es     = qs.pop_front();
          ecarry = qc.pop_front();
          eovf   = qo.pop_front();
          if ({s8_out_sum, s8_out_carry, s8_out_overflow} !== {es, ecarry, eovf}) begin
            errors++;
            $display("FAIL rand_beat%0d got sum=%h c=%b o=%b want sum=%h c=%b o=%b", popped,
                     s8_out_sum, s8_out_carry, s8_out_overflow, es, ecarry, eovf);
          end
        end
        popped++;
      end
      if (push) begin
        eb = s8_in_sub ? ~s8_in_b : s8_in_b;
        r  = {1'b0, s8_in_a} + {1'b0, eb} + {64'd0, s8_in_carry ^ s8_in_sub};
        qs.push_back(r[63:0]);
        qc.push_back(r[64]);
        qo.push_back((s8_in_a[63] == eb[63]) && (r[63] != s8_in_a[63]));
        accepted++;
      end
    end
    checks++;
    if (popped != 1000 || accepted != 1000) begin
      errors++; $display("FAIL rand_count got out=%0d in=%0d want 1000/1000", popped, accepted);
    end
    s8_in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    s2_in_valid = 1'b0; s2_in_a = '0; s2_in_b = '0; s2_in_carry = 1'b0; s2_in_sub = 1'b0;
    s2_out_ready = 1'b1;
    s4_in_valid = 1'b0; s4_in_a = '0; s4_in_b = '0; s4_in_carry = 1'b0; s4_in_sub = 1'b0;
    s4_out_ready = 1'b1;
    s8_in_valid = 1'b0; s8_in_a = '0; s8_in_b = '0; s8_in_carry = 1'b0; s8_in_sub = 1'b0;
    s8_out_ready = 1'b1;
    test_reset();
    test_add_wrap();
    test_vectors();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_adder_n.md
# pipelined_adder_n

Parametrised, fully pipelined add/subtract unit. It splits a WIDTH-bit operation into STAGES equal carry-chained slices and retires one slice per stage. A valid/ready handshake on input and output provides whole-pipeline stall. It supersedes the fixed 32-bit two-stage adder in datapaths that need wider operands, deeper pipelining, subtraction or backpressure.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of STAGES
- STAGES, 2, pipeline depth and slice count; 1..WIDTH
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  operand beat present
- in_ready  out  1  unit accepts a beat this cycle
- in_a  in  WIDTH  operand A (unsigned or two's complement)
- in_b  in  WIDTH  operand B
- in_carry  in  1  carry-in (add) / borrow-in (sub)
- in_sub  in  1  0 = add, 1 = subtract
- out_valid  out  1  result beat present
- out_ready  in  1  consumer accepts result
- out_sum  out  WIDTH  result
- out_carry  out  1  final carry-out; in sub mode 1 = no borrow
- out_overflow  out  1  signed two's-complement overflow

## Operation
- Slice width C = WIDTH/STAGES. Stage k (0..STAGES-1) adds bits [k*C+C-1 : k*C].
- Effective B = in_sub ? ~in_b : in_b. Carry into slice 0 = in_carry XOR in_sub.
  - Add computes A+B+cin.
  - Sub computes A−B−borrow_in.
- Operand slices not yet consumed ride forward in per-stage skew registers. Completed lower-slice sums ride forward with them. Each stage carries one valid bit.
- Output assembly:
  - out_sum = concatenation of all slice sums.
  - out_carry = carry out of the top slice.
  - out_overflow = carry into the MSB XOR carry out of the MSB, computed in the final slice.
- Global stall: advance = !out_valid || out_ready; in_ready = advance.
  - When advance = 1, every stage register loads from its predecessor. Stage 0 loads in_valid/operands.
  - When advance = 0, all stage registers hold, including invalid ones. Bubbles are not collapsed.
- A beat transfers in when in_valid && in_ready. A beat transfers out when out_valid && out_ready.
- Invalid stages propagate don't-care data with valid = 0. Only valid bits matter for control.
- STAGES = 1 degenerates to a single registered adder with the same handshake.

## Timing
- Reset (async assert; deassertion is synchronised externally):
  - All valid bits = 0, all data registers = 0.
  - out_valid = 0, out_sum = 0, out_carry = 0, out_overflow = 0.
  - in_ready = 1 (follows from out_valid = 0).
- Latency with no stall: a beat accepted at edge N appears on out_valid/out_sum after edge N+STAGES−1. It is first sampleable by the consumer at edge N+STAGES.
- Throughput: one beat per cycle while out_ready = 1.
- out_ready low with out_valid high: outputs hold exactly, in_ready = 0, no input is accepted. Upstream beats in flight are held, not lost.
- Simultaneous output pop and input push with a full pipeline: both occur, and occupancy is unchanged.
- in_ready is combinational from out_ready and out_valid. There is no combinational path from in_valid to any output.
- Reset mid-operation: all in-flight beats are discarded immediately. No partial result ever appears on out_valid.

## Structure
- Shared package adder_pkg holds `MODE_ADD = 1'b0` and `MODE_SUB = 1'b1`, plus a slice-width helper function (WIDTH/STAGES with a parameter legality check).
- One sub-module, adder_slice #(C): combinational C-bit add with carry in/out and MSB carry-in exposed for overflow. It is instantiated STAGES times via generate.
- Top level holds the valid chain, skew registers and stall logic.

## Test plan
- WIDTH=32, STAGES=2, add 0xFFFF_FFFF + 0x0000_0001, cin=0 → after 2 edges, sum 0x0000_0000, carry 1, overflow 0.
- WIDTH=32, STAGES=4, sub 0x0000_0005 − 0x0000_0007, borrow 0 → sum 0xFFFF_FFFE, carry 0, overflow 0; add 0x7FFF_FFFF + 1 → sum 0x8000_0000, overflow 1.
- STAGES=4, stream 8 back-to-back beats with out_ready=1 → 8 results in order on consecutive cycles, first result 4 edges after first accept.
- Full pipeline, out_ready low 3 cycles → out_sum held constant, in_ready 0, no input consumed, no beat lost or duplicated after release.
- Assert reset while 3 beats are in flight → out_valid 0 and outputs 0 immediately without a clock edge; after release the next accepted beat computes correctly.
- WIDTH=64, STAGES=8, random 1000 beats with random in_valid/out_ready → scoreboard against a reference add/sub model for sum, carry and overflow.
